// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller for the 5-stage 16-bit core
// Handles load-use stalls, branch flushes, imem/dmem waits, perf counters and a dmem watchdog.
module hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  IF_ID_Rs,
  input  logic [3:0]  IF_ID_Rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        EX_memread,
  input  logic [3:0]  EX_regtowrite,
  input  logic        ex_branch_taken,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  output logic        pc_wen,
  output logic        IF_ID_wen,
  output logic        ID_EX_wen,
  output logic        EX_MEM_wen,
  output logic        MEM_WB_wen,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

  state_t        state, state_next;
  logic          pend_flush;
  logic [WW-1:0] wait_cnt;
  logic          load_use;
  logic          do_flush;
  logic          do_ldstall;

  // EX holds the bubble while in LDSTALL, so a repeated match there is stale.
  assign load_use = EX_memread && (EX_regtowrite != 4'd0) &&
                    ((id_uses_rs && (IF_ID_Rs == EX_regtowrite)) ||
                     (id_uses_rt && (IF_ID_Rt == EX_regtowrite)));
  assign do_flush   = !dmem_stall && (pend_flush || ex_branch_taken);
  assign do_ldstall = !dmem_stall && !do_flush && load_use && (state != LDSTALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = RUN;
    if (dmem_stall) begin
      state_next = MEMWAIT;
    end else if (do_ldstall) begin
      state_next = LDSTALL;
    end
  end

  always_comb begin
    pc_wen       = 1'b1;
    IF_ID_wen    = 1'b1;
    ID_EX_wen    = 1'b1;
    EX_MEM_wen   = 1'b1;
    MEM_WB_wen   = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    if (dmem_stall) begin
      pc_wen     = 1'b0;
      IF_ID_wen  = 1'b0;
      ID_EX_wen  = 1'b0;
      EX_MEM_wen = 1'b0;
      MEM_WB_wen = 1'b0;
    end else if (do_flush) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (do_ldstall) begin
      pc_wen       = 1'b0;
      IF_ID_wen    = 1'b0;
      ID_EX_bubble = 1'b1;
    end else if (imem_stall) begin
      pc_wen      = 1'b0;
      IF_ID_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_flush   <= 1'b0;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= 16'h0000;
      flush_count  <= 16'h0000;
    end else begin
      if (dmem_stall) begin
        pend_flush <= pend_flush | ex_branch_taken;
        if (wait_cnt != WW'(TIMEOUT)) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        if (wait_cnt == WW'(TIMEOUT - 1)) begin
          mem_timeout <= 1'b1;
        end
      end else begin
        pend_flush <= 1'b0;
        wait_cnt   <= '0;
      end
      if (!pc_wen && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (do_flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Directed test-plan steps plus random traffic against a rule-level reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  IF_ID_Rs, IF_ID_Rt, EX_regtowrite;
  logic        id_uses_rs, id_uses_rt, EX_memread;
  logic        ex_branch_taken, imem_stall, dmem_stall;
  logic        pc_wen, IF_ID_wen, ID_EX_wen, EX_MEM_wen, MEM_WB_wen;
  logic        IF_ID_flush, ID_EX_bubble, mem_timeout;
  logic [15:0] stall_cycles, flush_count;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  bit m_prev_lu;
  bit m_pend;
  int m_wait;
  bit m_to;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .EX_memread(EX_memread), .EX_regtowrite(EX_regtowrite),
    .ex_branch_taken(ex_branch_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_wen(pc_wen), .IF_ID_wen(IF_ID_wen), .ID_EX_wen(ID_EX_wen),
    .EX_MEM_wen(EX_MEM_wen), .MEM_WB_wen(MEM_WB_wen),
    .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_lu = 0; m_pend = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock cycle: apply inputs at negedge, check combinational outputs,
  // advance the model at the edge, then check registered outputs.
  task automatic step(input bit r, input bit d, input bit br, input bit im, input bit mr,
                      input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                      input bit urs, input bit urt, input bit chk_comb = 1'b1);
    bit hazard, fl, ld, pc;
    logic [6:0] exp_vec;
    rst = r; dmem_stall = d; ex_branch_taken = br; imem_stall = im; EX_memread = mr;
    EX_regtowrite = rd; IF_ID_Rs = rs; IF_ID_Rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    hazard = mr && rd != 0 && ((urs && rs == rd) || (urt && rt == rd));
    fl = !d && (m_pend || br);
    ld = !d && !fl && hazard && !m_prev_lu;
    // order: pc, ifid, idex, exmem, memwb, flush, bubble
    if (d)           exp_vec = 7'b0000000;
    else if (fl)     exp_vec = 7'b1111111;
    else if (ld)     exp_vec = 7'b0011101;
    else if (im)     exp_vec = 7'b0111110;
    else             exp_vec = 7'b1111100;
    pc = exp_vec[6];
    #1;
    if (!r && chk_comb)
      chk("comb_ctl", {9'd0, pc_wen, IF_ID_wen, ID_EX_wen, EX_MEM_wen, MEM_WB_wen,
                       IF_ID_flush, ID_EX_bubble}, {9'd0, exp_vec});
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_prev_lu = ld;
      m_pend = d ? (m_pend || br) : 1'b0;
      m_wait = d ? m_wait + 1 : 0;
      if (m_wait >= 255) m_to = 1;
      if (!pc && m_stall < 65535) m_stall++;
      if (fl && m_flush < 65535) m_flush++;
    end
    @(negedge clk);
    if (chk_comb) begin
      chk("stall_cycles", stall_cycles, 16'(m_stall));
      chk("flush_count", flush_count, 16'(m_flush));
      chk("mem_timeout", {15'd0, mem_timeout}, {15'd0, m_to});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // load-use on Rs, then no stall for r0 or unused source
    step(0, 0, 0, 0, 1, 4'd3, 4'd3, 4'd5, 1, 0);
    step(0, 0, 0, 0, 1, 4'd3, 4'd3, 4'd5, 1, 0);
    chk("ld_stall_count", stall_cycles, 16'd1);
    step(0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 1, 1);
    step(0, 0, 0, 0, 1, 4'd3, 4'd3, 4'd5, 0, 0);
    step(0, 0, 0, 0, 1, 4'd7, 4'd1, 4'd7, 0, 1);
    idle(1);

    // branch overrides load-use; state stays RUN so next match stalls
    step(0, 0, 1, 0, 1, 4'd4, 4'd4, 4'd0, 1, 0);
    step(0, 0, 0, 0, 1, 4'd4, 4'd4, 4'd0, 1, 0);
    idle(1);

    // 4-cycle dmem stall with branch in first, flush on cycle 5
    rst = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("memwait_stalls", stall_cycles, 16'd4);
    chk("memwait_flush", flush_count, 16'd1);

    // reset mid-MEMWAIT with pend_flush set
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // watchdog: 256 stall cycles, sticky after release
    for (int i = 0; i < 256; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("timeout_sticky", {15'd0, mem_timeout}, 16'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_cleared", {15'd0, mem_timeout}, 16'd0);

    // imem stall for 2 cycles
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // randomized traffic with small register space to provoke matches
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // counter saturation: bring stall_cycles to FFFE, then stall 3 more
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0);
    chk("sat_preload", stall_cycles, 16'hFFFE);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_hold", stall_cycles, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
